ecdsa_project_wrapper: RTL and testbench

Top-level accelerator shell for the ECDSA project: an AXI4-Lite CSR slave, a host-visible 1024-bit-wide scratch RAM, and a job engine. The job engine gathers operand addresses from argument tables in RAM, computes coordinate-wise 1024-bit sums of two operand groups (e.g. point P and point Q components), and writes the results back through an output table. Software sets up RAM and CSRs, writes a start command, and polls status.

---
 rtl/ecdsa_project_wrapper.sv | 223 ++++++++++++++++++++++
 tb/tb_ecdsa_project_wrapper.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecdsa_project_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : ecdsa_project_wrapper
// Purpose  : AXI4-Lite CSR slave, dual-port 1024-bit scratch RAM and a job
//            engine that sums operand pairs gathered through RAM tables.
// Revision : 1.0
// ============================================================================
module ecdsa_project_wrapper #(
    parameter int MEM_WORDS = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          leds,
    input  logic [11:0]   s_axi_csrs_awaddr,
    input  logic          s_axi_csrs_awvalid,
    output logic          s_axi_csrs_awready,
    input  logic [31:0]   s_axi_csrs_wdata,
    input  logic [3:0]    s_axi_csrs_wstrb,
    input  logic          s_axi_csrs_wvalid,
    output logic          s_axi_csrs_wready,
    output logic [1:0]    s_axi_csrs_bresp,
    output logic          s_axi_csrs_bvalid,
    input  logic          s_axi_csrs_bready,
    input  logic [11:0]   s_axi_csrs_araddr,
    input  logic          s_axi_csrs_arvalid,
    output logic          s_axi_csrs_arready,
    output logic [31:0]   s_axi_csrs_rdata,
    output logic [1:0]    s_axi_csrs_rresp,
    output logic          s_axi_csrs_rvalid,
    input  logic          s_axi_csrs_rready,
    input  logic [16:0]   mem_addr,
    input  logic [1023:0] mem_din,
    output logic [1023:0] mem_dout,
    input  logic          mem_en,
    input  logic [127:0]  mem_we
);
    localparam int c_AW = $clog2(MEM_WORDS);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RD_TI = 3'd1;
    localparam logic [2:0] c_RD_TO = 3'd2;
    localparam logic [2:0] c_RD_A  = 3'd3;
    localparam logic [2:0] c_RD_B  = 3'd4;
    localparam logic [2:0] c_WR    = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    logic [1023:0] r_mem [MEM_WORDS];
    logic [1023:0] r_b_dout, r_tbl_i, r_tbl_o, r_op_a, r_sum;
    logic [31:0]   r_base_i, r_argc_i, r_base_o, r_argc_o, w_b_addr, w_rd_mux;
    logic [11:0]   r_awaddr;
    logic [2:0]    r_state;
    logic [4:0]    r_k, r_n;
    logic          r_phase, r_done, r_err, r_job_err, r_aw_pending;
    logic          w_busy, w_wr_hs, w_cmd_wr, w_argc_ok, w_b_we, w_unused;
    logic [c_AW-1:0] w_a_idx, w_b_idx;

    // Entry k of a table word sits at bits [1023-32k : 992-32k].
    function automatic logic [31:0] f_entry(input logic [1023:0] tbl, input logic [4:0] k);
        return 32'(tbl >> {5'd31 - k, 5'd0});
    endfunction

    assign w_a_idx   = mem_addr[7 +: c_AW];
    assign w_b_idx   = w_b_addr[7 +: c_AW];
    assign w_busy    = (r_state != c_IDLE);
    assign w_wr_hs   = s_axi_csrs_wready && s_axi_csrs_wvalid;
    assign w_cmd_wr  = w_wr_hs && (r_awaddr == 12'h000);
    assign w_argc_ok = (r_argc_o != 32'd0) && (r_argc_o <= 32'd16) &&
                       ({1'b0, r_argc_i} == {r_argc_o, 1'b0});
    assign w_b_we    = (r_state == c_WR) && !rst;
    assign leds      = r_done;
    assign s_axi_csrs_bresp = 2'b00;
    assign s_axi_csrs_rresp = 2'b00;
    assign w_unused  = ^{s_axi_csrs_wstrb, mem_addr, w_b_addr, r_base_i, r_base_o};

    always_comb begin
        w_b_addr = '0;
        case (r_state)
            c_RD_TI: w_b_addr = r_base_i;
            c_RD_TO: w_b_addr = r_base_o;
            c_RD_A:  w_b_addr = f_entry(r_tbl_i, r_k);
            c_RD_B:  w_b_addr = f_entry(r_tbl_i, 5'(r_k + r_n));
            c_WR:    w_b_addr = f_entry(r_tbl_o, r_k);
            default: w_b_addr = '0;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (s_axi_csrs_araddr)
            12'h000: w_rd_mux = {29'd0, w_busy, r_err, r_done};
            12'h004: w_rd_mux = r_base_i;
            12'h008: w_rd_mux = r_argc_i;
            12'h00C: w_rd_mux = r_base_o;
            12'h010: w_rd_mux = r_argc_o;
            default: w_rd_mux = '0;
        endcase
    end

    // Host bytes are assigned after the engine word so they win on a collision.
    always_ff @(posedge clk) begin
        if (w_b_we)
            r_mem[w_b_idx] <= r_sum;
        if (mem_en)
            for (int i = 0; i < 128; i++)
                if (mem_we[i])
                    r_mem[w_a_idx][8*i +: 8] <= mem_din[8*i +: 8];
        r_b_dout <= r_mem[w_b_idx];
    end

    always_ff @(posedge clk) begin
        if (rst)
            mem_dout <= '0;
        else if (mem_en)
            mem_dout <= r_mem[w_a_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_csrs_awready <= 1'b0;
            s_axi_csrs_wready  <= 1'b0;
            s_axi_csrs_bvalid  <= 1'b0;
            s_axi_csrs_arready <= 1'b0;
            s_axi_csrs_rvalid  <= 1'b0;
            s_axi_csrs_rdata   <= '0;
            r_aw_pending       <= 1'b0;
            r_awaddr           <= '0;
            r_base_i           <= '0;
            r_argc_i           <= '0;
            r_base_o           <= '0;
            r_argc_o           <= '0;
        end else begin
            s_axi_csrs_awready <= s_axi_csrs_awvalid && !s_axi_csrs_awready &&
                                  !r_aw_pending && !s_axi_csrs_bvalid;
            if (s_axi_csrs_awvalid && s_axi_csrs_awready) begin
                r_aw_pending      <= 1'b1;
                r_awaddr          <= s_axi_csrs_awaddr;
                s_axi_csrs_wready <= 1'b1;
            end
            if (w_wr_hs) begin
                s_axi_csrs_wready <= 1'b0;
                s_axi_csrs_bvalid <= 1'b1;
                r_aw_pending      <= 1'b0;
                case (r_awaddr)
                    12'h004: r_base_i <= s_axi_csrs_wdata;
                    12'h008: r_argc_i <= s_axi_csrs_wdata;
                    12'h00C: r_base_o <= s_axi_csrs_wdata;
                    12'h010: r_argc_o <= s_axi_csrs_wdata;
                    default: ;
                endcase
            end else if (s_axi_csrs_bvalid && s_axi_csrs_bready) begin
                s_axi_csrs_bvalid <= 1'b0;
            end
            s_axi_csrs_arready <= s_axi_csrs_arvalid && !s_axi_csrs_arready && !s_axi_csrs_rvalid;
            if (s_axi_csrs_arvalid && s_axi_csrs_arready) begin
                s_axi_csrs_rvalid <= 1'b1;
                s_axi_csrs_rdata  <= w_rd_mux;
            end else if (s_axi_csrs_rvalid && s_axi_csrs_rready) begin
                s_axi_csrs_rvalid <= 1'b0;
            end
        end
    end

    // Each read state spends one cycle issuing the address, one consuming data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_phase   <= 1'b0;
            r_k       <= '0;
            r_n       <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_job_err <= 1'b0;
            r_tbl_i   <= '0;
            r_tbl_o   <= '0;
            r_op_a    <= '0;
            r_sum     <= '0;
        end else begin
            if (w_cmd_wr && !s_axi_csrs_wdata[1]) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_cmd_wr && s_axi_csrs_wdata[1]) begin
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_k       <= '0;
                        r_n       <= r_argc_o[4:0];
                        r_phase   <= 1'b0;
                        r_job_err <= !w_argc_ok;
                        r_state   <= w_argc_ok ? c_RD_TI : c_DONE;
                    end
                end
                c_RD_TI, c_RD_TO, c_RD_A, c_RD_B: begin
                    r_phase <= !r_phase;
                    if (r_phase) begin
                        case (r_state)
                            c_RD_TI: begin r_tbl_i <= r_b_dout; r_state <= c_RD_TO; end
                            c_RD_TO: begin r_tbl_o <= r_b_dout; r_state <= c_RD_A;  end
                            c_RD_A:  begin r_op_a  <= r_b_dout; r_state <= c_RD_B;  end
                            default: begin r_sum <= r_op_a + r_b_dout; r_state <= c_WR; end
                        endcase
                    end
                end
                c_WR: begin
                    if (r_k == 5'(r_n - 5'd1)) begin
                        r_state <= c_DONE;
                    end else begin
                        r_k     <= r_k + 5'd1;
                        r_state <= c_RD_A;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b1;
                    r_err   <= r_job_err;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ecdsa_project_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecdsa_project_wrapper
// Purpose  : Directed self-checking bench for ecdsa_project_wrapper.
// Revision : 1.0
// ============================================================================
module tb_ecdsa_project_wrapper;
    logic          clk = 1'b0;
    logic          rst;
    logic          leds;
    logic [11:0]   awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [16:0]   mem_addr;
    logic [1023:0] mem_din, mem_dout;
    logic          mem_en;
    logic [127:0]  mem_we;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int start_cyc = 0;
    logic [1:0] resp_or = 2'b00;

    ecdsa_project_wrapper #(.MEM_WORDS(16)) dut (
        .clk(clk), .rst(rst), .leds(leds),
        .s_axi_csrs_awaddr(awaddr), .s_axi_csrs_awvalid(awvalid), .s_axi_csrs_awready(awready),
        .s_axi_csrs_wdata(wdata), .s_axi_csrs_wstrb(wstrb), .s_axi_csrs_wvalid(wvalid),
        .s_axi_csrs_wready(wready), .s_axi_csrs_bresp(bresp), .s_axi_csrs_bvalid(bvalid),
        .s_axi_csrs_bready(bready), .s_axi_csrs_araddr(araddr), .s_axi_csrs_arvalid(arvalid),
        .s_axi_csrs_arready(arready), .s_axi_csrs_rdata(rdata), .s_axi_csrs_rresp(rresp),
        .s_axi_csrs_rvalid(rvalid), .s_axi_csrs_rready(rready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_en(mem_en), .mem_we(mem_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int c;
        checks++;
        assert (obs === exp) else begin
            errors++;
            c = 0;
            for (int i = 7; i >= 0; i--)
                if (obs[128*i +: 128] !== exp[128*i +: 128]) c = i;
            $error("FAIL %s slice%0d observed %h expected %h", tag, c,
                   obs[128*c +: 128], exp[128*c +: 128]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int t;
        logic aw_now, w_now, w_ok, b_ok;
        awaddr = a; awvalid = 1'b1; wdata = d; wvalid = 1'b1; bready = 1'b1;
        w_ok = 1'b0; b_ok = 1'b0; t = 0;
        while (!w_ok && t < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            step(1); t++;
            if (aw_now) awvalid = 1'b0;
            if (w_now) begin w_ok = 1'b1; wvalid = 1'b0; hs_cyc = cyc; end
        end
        t = 0;
        while (!bvalid && t < 10) begin step(1); t++; end
        if (bvalid) begin b_ok = 1'b1; resp_or = resp_or | bresp; step(1); end
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("axi_write_handshake", {w_ok, b_ok}, 2'b11);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int t;
        logic ar_ok;
        araddr = a; arvalid = 1'b1; rready = 1'b0; ar_ok = 1'b0; t = 0; d = 'x;
        while (!ar_ok && t < 20) begin
            ar_ok = arready;
            step(1); t++;
        end
        arvalid = 1'b0; t = 0;
        while (!rvalid && t < 10) begin step(1); t++; end
        chk("axi_read_handshake", {ar_ok, rvalid}, 2'b11);
        if (rvalid) begin
            d = rdata; resp_or = resp_or | rresp;
            rready = 1'b1; step(1); rready = 1'b0;
        end
    endtask

    task automatic mem_wr(input logic [16:0] a, input logic [1023:0] d);
        mem_addr = a; mem_din = d; mem_we = '1; mem_en = 1'b1;
        step(1);
        mem_we = '0; mem_en = 1'b0;
    endtask

    task automatic mem_rd(input logic [16:0] a, output logic [1023:0] d);
        mem_addr = a; mem_en = 1'b1;
        step(1);
        d = mem_dout; mem_en = 1'b0;
    endtask

    task automatic wait_done(output int el);
        int t;
        t = 0;
        while (!leds && t < 40) begin step(1); t++; end
        el = cyc - start_cyc;
        chk("done_seen", leds, 1'b1);
    endtask

    function automatic logic [1023:0] mk_table(input logic [31:0] e0, e1, e2, e3, e4, e5);
        logic [1023:0] t;
        t = '0;
        t[1023 -: 32] = e0; t[991 -: 32] = e1; t[959 -: 32] = e2;
        t[927 -: 32] = e3;  t[895 -: 32] = e4; t[863 -: 32] = e5;
        return t;
    endfunction

    initial begin
        logic [1023:0] one, d;
        logic [31:0] r;
        int el;
        one = 1024'd1;
        rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        mem_addr = '0; mem_din = '0; mem_en = 1'b0; mem_we = '0;
        step(3);
        chk("reset_leds", leds, 1'b0);
        chk("reset_mem_dout", mem_dout, '0);
        chk("reset_axi_valid_ready", {awready, wready, bvalid, arready, rvalid}, 5'b0);
        chk("reset_resp", {bresp, rresp}, 4'b0);
        rst = 1'b0;
        step(1);
        axi_read(12'h000, r); chk("reset_status", r, 32'd0);
        axi_read(12'h008, r); chk("reset_argc_i", r, 32'd0);

        // CSR readback
        axi_write(12'h004, 32'h0);
        axi_write(12'h008, 32'd6);
        axi_write(12'h00C, 32'h400);
        axi_write(12'h010, 32'd3);
        axi_read(12'h004, r); chk("csr_base_i", r, 32'h0);
        axi_read(12'h008, r); chk("csr_argc_i", r, 32'd6);
        axi_read(12'h00C, r); chk("csr_base_o", r, 32'h400);
        axi_read(12'h010, r); chk("csr_argc_o", r, 32'd3);
        axi_read(12'h020, r); chk("csr_unmapped", r, 32'd0);

        // Example job
        mem_wr(17'h080, one << 643); mem_wr(17'h100, 1024'd2 << 643); mem_wr(17'h180, 1024'd3 << 643);
        mem_wr(17'h200, one << 643); mem_wr(17'h280, 1024'd2 << 643); mem_wr(17'h300, 1024'd3 << 643);
        mem_wr(17'h000, mk_table(32'h80, 32'h100, 32'h180, 32'h200, 32'h280, 32'h300));
        mem_wr(17'h400, mk_table(32'h480, 32'h500, 32'h580, 0, 0, 0));
        mem_wr(17'h480, '0); mem_wr(17'h500, '0); mem_wr(17'h580, '0);
        axi_write(12'h000, 32'd2);
        start_cyc = hs_cyc;
        axi_read(12'h000, r); chk("status_busy", r, 32'h4);
        wait_done(el);
        chk("job_latency_ok", el <= 22, 1'b1);
        axi_read(12'h000, r); chk("status_done", r, 32'h1);
        mem_rd(17'h480, d); chk("res0", d, 1024'd2 << 643);
        mem_rd(17'h500, d); chk("res1", d, 1024'd4 << 643);
        mem_rd(17'h580, d); chk("res2", d, 1024'd6 << 643);

        // Clear
        axi_write(12'h000, 32'd0);
        axi_read(12'h000, r); chk("status_cleared", r, 32'h0);
        chk("leds_cleared", leds, 1'b0);

        // Bad argc
        axi_write(12'h008, 32'd5);
        axi_write(12'h000, 32'd2);
        start_cyc = hs_cyc;
        wait_done(el);
        axi_read(12'h000, r); chk("status_bad_argc", r, 32'h3);
        mem_rd(17'h480, d); chk("bad_res0_kept", d, 1024'd2 << 643);
        mem_rd(17'h580, d); chk("bad_res2_kept", d, 1024'd6 << 643);
        axi_write(12'h000, 32'd0);

        // Carry wraps out of 1024 bits; result address also tests index wrap
        mem_wr(17'h600, '1); mem_wr(17'h680, 1024'd2); mem_wr(17'h380, '0);
        mem_wr(17'h700, mk_table(32'h600, 32'h680, 0, 0, 0, 0));
        mem_wr(17'h780, mk_table(32'h380, 0, 0, 0, 0, 0));
        axi_write(12'h004, 32'h700); axi_write(12'h008, 32'd2);
        axi_write(12'h00C, 32'h780); axi_write(12'h010, 32'd1);
        axi_write(12'h000, 32'd2);
        start_cyc = hs_cyc;
        wait_done(el);
        axi_read(12'h000, r); chk("status_wrap_done", r, 32'h1);
        mem_rd(17'h380, d); chk("wrap_sum", d, 1024'd1);
        mem_rd(17'h0B80, d); chk("addr_index_wrap", d, 1024'd1);

        // Second start while busy must be ignored
        axi_write(12'h000, 32'd0);
        axi_write(12'h004, 32'h0); axi_write(12'h008, 32'd6);
        axi_write(12'h00C, 32'h400); axi_write(12'h010, 32'd3);
        mem_wr(17'h480, '0); mem_wr(17'h500, '0); mem_wr(17'h580, '0);
        axi_write(12'h000, 32'd2);
        start_cyc = hs_cyc;
        axi_write(12'h000, 32'd2);
        wait_done(el);
        chk("restart_latency_ok", el <= 22, 1'b1);
        el = 0;
        for (int i = 0; i < 30; i++) begin step(1); if (!leds) el++; end
        chk("single_completion", el, 0);
        mem_rd(17'h480, d); chk("restart_res0", d, 1024'd2 << 643);
        mem_rd(17'h500, d); chk("restart_res1", d, 1024'd4 << 643);
        mem_rd(17'h580, d); chk("restart_res2", d, 1024'd6 << 643);

        // Reset mid-job
        mem_wr(17'h480, '0); mem_wr(17'h500, '0); mem_wr(17'h580, '0);
        axi_write(12'h000, 32'd2);
        start_cyc = hs_cyc;
        el = 0;
        while (cyc < start_cyc + 3 && el < 20) begin step(1); el++; end
        rst = 1'b1; step(1); rst = 1'b0;
        chk("midreset_leds", leds, 1'b0);
        axi_read(12'h000, r); chk("midreset_status", r, 32'h0);
        step(30);
        axi_read(12'h000, r); chk("midreset_status_later", r, 32'h0);
        mem_rd(17'h480, d); chk("midreset_res0", d, '0);
        mem_rd(17'h500, d); chk("midreset_res1", d, '0);
        mem_rd(17'h580, d); chk("midreset_res2", d, '0);

        chk("all_resp_okay", resp_or, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
